decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised decode stage for the pipelined RV32I core. It buffers up to DEPTH fetched instructions with their PCs in a FIFO and decodes the head entry into the standard control bundle. The decoded bundle is registered into a valid/ready output slot that feeds the ID/EX boundary. Compared with the combinational decoder it adds fetch/execute decoupling, synchronous flush, illegal-instruction flagging and optional RV32M decode.

## Interface

Parameters:
- DEPTH, 4: FIFO entries, power of two, minimum 2. Total capacity is DEPTH+1 including the output slot.
- PC_W, 32: PC width carried alongside each instruction.
- M_EXT, 1: 1 decodes RV32M (opcode 0110011, funct7 0000001). 0 flags those encodings illegal.

Ports:
- clk, in, 1: clock; all state updates on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: fetch presents an instruction.
- in_ready, out, 1: queue can accept; equals count<DEPTH; no combinational path from out_ready.
- in_inst, in, 32: instruction word.
- in_pc, in, PC_W: its PC.
- flush, in, 1: synchronous kill of all buffered and output state.
- out_valid, out, 1: output slot holds a decoded instruction.
- out_ready, in, 1: consumer accepts the slot this cycle.
- out_inst, out, 32: raw instruction word of the output slot.
- out_pc, out, PC_W: PC of the output slot.
- jal, jalr, op1_src, op2_src, load_npc, wb_select, reg_write_en, csr_write_en, csr_zimm_or_reg, out, 1 each: control bits, meanings as in the core decoder.
- alu_func, out, 4: ALU operation.
- br_type, out, 3: branch condition.
- load_type, out, 3: load width/sign.
- cache_write_en, out, 4: store byte mask.
- imm_type, out, 3: immediate format.
- md_en, out, 1: multiply/divide instruction.
- md_func, out, 3: funct3 of the M instruction.
- illegal, out, 1: unrecognised encoding.

## Operation

- FIFO: circular buffer of {inst, pc}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Push: occurs when in_valid && in_ready && !flush.
- Pop / load of output slot:
  - Condition: count>0 && (!out_valid || out_ready) && !flush.
  - The head is decoded combinationally and the full bundle plus inst/pc is registered into the slot; out_valid becomes 1.
  - If the slot is consumed (out_valid && out_ready) with count==0, out_valid becomes 0.
- Simultaneous push and pop: count is unchanged. At count==DEPTH, in_ready=0, so no push can occur in the same cycle as a pop.
- Decode rules, with encodings from Parameters.v:
  - LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD, STORE, BRANCH and SYSTEM/CSR are decoded identically to the existing core decoder.
  - Store masks: SB 0001, SH 0011, SW 1111.
  - CSR: CSRRW/CSRRWI give OP1; CSRRS/CSRRSI give OR; CSRRC/CSRRCI give OP2. zimm=1 for the I variants.
- M decode, when M_EXT=1:
  - Applies to opcode 0110011 with funct7 0000001.
  - Outputs: md_en=1, md_func=funct3, reg_write_en=1, op1_src=0, op2_src=0, alu_func=0, imm_type=RTYPE.
- Illegal encodings: unknown opcode, undefined funct3/funct7 combinations, and M encodings when M_EXT=0.
  - Outputs: illegal=1, and all enables (reg_write_en, cache_write_en, csr_write_en, jal, jalr, md_en) and br_type are 0.
  - The entry is still delivered with out_valid=1, so the trap logic sees the PC.
- Flush:
  - Next edge: count=0, both pointers=0, out_valid=0.
  - in_valid is ignored in the flush cycle.
  - Flush has priority over push, pop and out_ready.
- Reset: same state as flush, plus all control outputs, out_inst, out_pc, md_func and illegal cleared to 0.
- Output data when out_valid=0:
  - Holds the last loaded value, except after reset or flush where it is 0.
  - Consumers must qualify all outputs with out_valid.

## Timing

- Latency:
  - Push at edge N into an empty queue with an empty slot: out_valid=1 after edge N+1.
  - Pushes do not bypass the FIFO into the slot.
- Throughput: one instruction per cycle with out_ready held high.
- Backpressure:
  - Slot contents remain stable while out_valid && !out_ready.
  - in_ready falls on the edge where count reaches DEPTH.
- Asynchronous rst clears state immediately, independent of clk. Deassertion takes effect at the next edge.

## Test plan

- Basic flow: push 0x003100B3 (add x1,x2,x3) with out_ready=1.
  - out_valid is set 2 cycles later.
  - Bundle: alu_func=ADD, reg_write_en=1, op2_src=0, illegal=0.
- Load/store decode:
  - 0x00812283 (lw) → wb_select=1, load_type=LW, imm_type=ITYPE.
  - 0x00512423 (sw) → cache_write_en=1111, reg_write_en=0.
- M extension: push 0x023100B3 (mul).
  - M_EXT=1 → md_en=1, md_func=000.
  - M_EXT=0 → illegal=1, reg_write_en=0.
- Full and backpressure with DEPTH=4 and out_ready=0: push 6 instructions back to back.
  - in_ready drops after the 5th is accepted; the 6th waits.
  - The slot holds the 1st instruction stably.
  - Raise out_ready: the 5 instructions emerge in order on consecutive cycles, and the 6th follows.
- Wrap-around: stream 20 instructions with random out_ready.
  - PC sequence out equals PC sequence in.
  - No loss and no duplication.
- Flush:
  - With 3 entries queued and out_valid=1, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the pushed instruction is dropped.
  - Assert rst mid-stream → outputs become 0 without waiting for a clock edge.

Source files
------------

// File: rtl/decode_queue.sv
// Instruction queue plus RV32I/M decoder feeding a registered valid/ready output slot.
// Total buffering is DEPTH FIFO entries plus the output slot.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int M_EXT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [PC_W-1:0] out_pc,
  output logic            jal,
  output logic            jalr,
  output logic            op1_src,
  output logic            op2_src,
  output logic            load_npc,
  output logic            wb_select,
  output logic            reg_write_en,
  output logic            csr_write_en,
  output logic            csr_zimm_or_reg,
  output logic [3:0]      alu_func,
  output logic [2:0]      br_type,
  output logic [2:0]      load_type,
  output logic [3:0]      cache_write_en,
  output logic [2:0]      imm_type,
  output logic            md_en,
  output logic [2:0]      md_func,
  output logic            illegal
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_SRA = 4'd2, ALU_ADD = 4'd3,
                         ALU_SUB = 4'd4, ALU_XOR = 4'd5, ALU_OR = 4'd6, ALU_AND = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_LUI = 4'd10, ALU_OP1 = 4'd11,
                         ALU_OP2 = 4'd12;
  localparam logic [2:0] BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3, BR_BLTU = 3'd4,
                         BR_BGE = 3'd5, BR_BGEU = 3'd6;
  localparam logic [2:0] IMM_R = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3,
                         IMM_U = 3'd4, IMM_J = 3'd5;
  localparam logic [2:0] LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3, LD_LBU = 3'd4, LD_LHU = 3'd5;

  typedef struct packed {
    logic       jal;
    logic       jalr;
    logic       op1_src;
    logic       op2_src;
    logic       load_npc;
    logic       wb_select;
    logic       reg_write_en;
    logic       csr_write_en;
    logic       csr_zimm_or_reg;
    logic [3:0] alu_func;
    logic [2:0] br_type;
    logic [2:0] load_type;
    logic [3:0] cache_write_en;
    logic [2:0] imm_type;
    logic       md_en;
    logic [2:0] md_func;
    logic       illegal;
  } ctrl_t;

  logic [31:0]     mem_inst [DEPTH];
  logic [PC_W-1:0] mem_pc   [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            push, pop;
  logic [31:0]     head_inst;
  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  ctrl_t           ctrl_d, ctrl_q;

  // in_ready depends only on registered count, never on out_ready
  assign in_ready  = (count < (AW+1)'(DEPTH));
  assign push      = in_valid && in_ready && !flush;
  assign pop       = (count != '0) && (!out_valid || out_ready) && !flush;
  assign head_inst = mem_inst[rd_ptr];
  assign opcode    = head_inst[6:0];
  assign f3        = head_inst[14:12];
  assign f7        = head_inst[31:25];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= in_inst;
      mem_pc[wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_comb begin
    ctrl_d = '0;
    unique case (opcode)
      7'b0110111: begin
        ctrl_d.alu_func = ALU_LUI; ctrl_d.op2_src = 1'b1;
        ctrl_d.imm_type = IMM_U;   ctrl_d.reg_write_en = 1'b1;
      end
      7'b0010111: begin
        ctrl_d.alu_func = ALU_ADD; ctrl_d.op1_src = 1'b1; ctrl_d.op2_src = 1'b1;
        ctrl_d.imm_type = IMM_U;   ctrl_d.reg_write_en = 1'b1;
      end
      7'b1101111: begin
        ctrl_d.jal = 1'b1; ctrl_d.load_npc = 1'b1; ctrl_d.reg_write_en = 1'b1;
        ctrl_d.alu_func = ALU_ADD; ctrl_d.imm_type = IMM_J;
      end
      7'b1100111: begin
        ctrl_d.jalr = 1'b1; ctrl_d.load_npc = 1'b1; ctrl_d.reg_write_en = 1'b1;
        ctrl_d.op2_src = 1'b1; ctrl_d.alu_func = ALU_ADD; ctrl_d.imm_type = IMM_I;
        ctrl_d.illegal = (f3 != 3'b000);
      end
      7'b0110011: begin
        ctrl_d.reg_write_en = 1'b1;
        ctrl_d.imm_type     = IMM_R;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  ctrl_d.alu_func = ALU_ADD;
            3'b001:  ctrl_d.alu_func = ALU_SLL;
            3'b010:  ctrl_d.alu_func = ALU_SLT;
            3'b011:  ctrl_d.alu_func = ALU_SLTU;
            3'b100:  ctrl_d.alu_func = ALU_XOR;
            3'b101:  ctrl_d.alu_func = ALU_SRL;
            3'b110:  ctrl_d.alu_func = ALU_OR;
            default: ctrl_d.alu_func = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          ctrl_d.alu_func = ALU_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          ctrl_d.alu_func = ALU_SRA;
        end else if (f7 == 7'b0000001 && M_EXT != 0) begin
          ctrl_d.md_en   = 1'b1;
          ctrl_d.md_func = f3;
        end else begin
          ctrl_d.illegal = 1'b1;
        end
      end
      7'b0010011: begin
        ctrl_d.reg_write_en = 1'b1; ctrl_d.op2_src = 1'b1; ctrl_d.imm_type = IMM_I;
        case (f3)
          3'b000:  ctrl_d.alu_func = ALU_ADD;
          3'b001: begin
            ctrl_d.alu_func = ALU_SLL;
            ctrl_d.illegal  = (f7 != 7'b0000000);
          end
          3'b010:  ctrl_d.alu_func = ALU_SLT;
          3'b011:  ctrl_d.alu_func = ALU_SLTU;
          3'b100:  ctrl_d.alu_func = ALU_XOR;
          3'b101: begin
            ctrl_d.alu_func = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            ctrl_d.illegal  = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end
          3'b110:  ctrl_d.alu_func = ALU_OR;
          default: ctrl_d.alu_func = ALU_AND;
        endcase
      end
      7'b0000011: begin
        ctrl_d.reg_write_en = 1'b1; ctrl_d.wb_select = 1'b1; ctrl_d.op2_src = 1'b1;
        ctrl_d.alu_func = ALU_ADD;  ctrl_d.imm_type = IMM_I;
        case (f3)
          3'b000:  ctrl_d.load_type = LD_LB;
          3'b001:  ctrl_d.load_type = LD_LH;
          3'b010:  ctrl_d.load_type = LD_LW;
          3'b100:  ctrl_d.load_type = LD_LBU;
          3'b101:  ctrl_d.load_type = LD_LHU;
          default: ctrl_d.illegal   = 1'b1;
        endcase
      end
      7'b0100011: begin
        ctrl_d.op2_src = 1'b1; ctrl_d.alu_func = ALU_ADD; ctrl_d.imm_type = IMM_S;
        case (f3)
          3'b000:  ctrl_d.cache_write_en = 4'b0001;
          3'b001:  ctrl_d.cache_write_en = 4'b0011;
          3'b010:  ctrl_d.cache_write_en = 4'b1111;
          default: ctrl_d.illegal        = 1'b1;
        endcase
      end
      7'b1100011: begin
        ctrl_d.imm_type = IMM_B;
        case (f3)
          3'b000:  ctrl_d.br_type = BR_BEQ;
          3'b001:  ctrl_d.br_type = BR_BNE;
          3'b100:  ctrl_d.br_type = BR_BLT;
          3'b101:  ctrl_d.br_type = BR_BGE;
          3'b110:  ctrl_d.br_type = BR_BLTU;
          3'b111:  ctrl_d.br_type = BR_BGEU;
          default: ctrl_d.illegal = 1'b1;
        endcase
      end
      7'b1110011: begin
        // only the CSR forms are recognised; ECALL/EBREAK (funct3 000) trap as illegal
        ctrl_d.csr_write_en    = 1'b1;
        ctrl_d.reg_write_en    = 1'b1;
        ctrl_d.csr_zimm_or_reg = f3[2];
        ctrl_d.imm_type        = IMM_I;
        case (f3[1:0])
          2'b01:   ctrl_d.alu_func = ALU_OP1;
          2'b10:   ctrl_d.alu_func = ALU_OR;
          2'b11:   ctrl_d.alu_func = ALU_OP2;
          default: ctrl_d.illegal  = 1'b1;
        endcase
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
    if (ctrl_d.illegal) begin
      ctrl_d         = '0;
      ctrl_d.illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      out_inst  <= '0;
      out_pc    <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      ctrl_q    <= ctrl_d;
      out_inst  <= head_inst;
      out_pc    <= mem_pc[rd_ptr];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign jal             = ctrl_q.jal;
  assign jalr            = ctrl_q.jalr;
  assign op1_src         = ctrl_q.op1_src;
  assign op2_src         = ctrl_q.op2_src;
  assign load_npc        = ctrl_q.load_npc;
  assign wb_select       = ctrl_q.wb_select;
  assign reg_write_en    = ctrl_q.reg_write_en;
  assign csr_write_en    = ctrl_q.csr_write_en;
  assign csr_zimm_or_reg = ctrl_q.csr_zimm_or_reg;
  assign alu_func        = ctrl_q.alu_func;
  assign br_type         = ctrl_q.br_type;
  assign load_type       = ctrl_q.load_type;
  assign cache_write_en  = ctrl_q.cache_write_en;
  assign imm_type        = ctrl_q.imm_type;
  assign md_en           = ctrl_q.md_en;
  assign md_func         = ctrl_q.md_func;
  assign illegal         = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: one M-enabled and one M-disabled instance share stimulus.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, jal, jalr, op1_src, op2_src, load_npc, wb_select;
  logic        reg_write_en, csr_write_en, csr_zimm_or_reg, md_en, illegal;
  logic [31:0] out_inst, out_pc;
  logic [3:0]  alu_func, cache_write_en;
  logic [2:0]  br_type, load_type, imm_type, md_func;

  logic        n_in_ready, n_out_valid, n_jal, n_jalr, n_op1_src, n_op2_src, n_load_npc;
  logic        n_wb_select, n_reg_write_en, n_csr_write_en, n_csr_zimm_or_reg, n_md_en, n_illegal;
  logic [31:0] n_out_inst, n_out_pc;
  logic [3:0]  n_alu_func, n_cache_write_en;
  logic [2:0]  n_br_type, n_load_type, n_imm_type, n_md_func;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(4), .PC_W(32), .M_EXT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .jal(jal), .jalr(jalr), .op1_src(op1_src),
    .op2_src(op2_src), .load_npc(load_npc), .wb_select(wb_select),
    .reg_write_en(reg_write_en), .csr_write_en(csr_write_en),
    .csr_zimm_or_reg(csr_zimm_or_reg), .alu_func(alu_func), .br_type(br_type),
    .load_type(load_type), .cache_write_en(cache_write_en), .imm_type(imm_type),
    .md_en(md_en), .md_func(md_func), .illegal(illegal)
  );

  decode_queue #(.DEPTH(4), .PC_W(32), .M_EXT(0)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .out_valid(n_out_valid), .out_ready(out_ready),
    .out_inst(n_out_inst), .out_pc(n_out_pc), .jal(n_jal), .jalr(n_jalr),
    .op1_src(n_op1_src), .op2_src(n_op2_src), .load_npc(n_load_npc),
    .wb_select(n_wb_select), .reg_write_en(n_reg_write_en),
    .csr_write_en(n_csr_write_en), .csr_zimm_or_reg(n_csr_zimm_or_reg),
    .alu_func(n_alu_func), .br_type(n_br_type), .load_type(n_load_type),
    .cache_write_en(n_cache_write_en), .imm_type(n_imm_type), .md_en(n_md_en),
    .md_func(n_md_func), .illegal(n_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sent, recv;

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_alu_func", alu_func, 0);
    rst = 1'b0;
    tick();

    // add x1,x2,x3: two-edge latency, no bypass
    in_valid = 1'b1; in_inst = 32'h003100B3; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("add_no_bypass", out_valid, 0);
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_inst", out_inst, 32'h003100B3);
    chk("add_pc", out_pc, 32'h100);
    chk("add_alu", alu_func, 4'd3);
    chk("add_rwe", reg_write_en, 1);
    chk("add_op2", op2_src, 0);
    chk("add_illegal", illegal, 0);
    tick();
    chk("add_drain", out_valid, 0);
    chk("add_hold_inst", out_inst, 32'h003100B3);

    // back-to-back decode stream
    in_valid = 1'b1; in_inst = 32'h00812283; in_pc = 32'h200;
    tick();
    in_inst = 32'h00512423; in_pc = 32'h204;
    tick();
    chk("lw_wb", wb_select, 1);
    chk("lw_type", load_type, 3'd3);
    chk("lw_imm", imm_type, 3'd1);
    chk("lw_pc", out_pc, 32'h200);
    in_inst = 32'h023100B3; in_pc = 32'h208;
    tick();
    chk("sw_mask", cache_write_en, 4'b1111);
    chk("sw_rwe", reg_write_en, 0);
    chk("sw_imm", imm_type, 3'd2);
    in_inst = 32'h00208463; in_pc = 32'h20C;
    tick();
    chk("mul_md_en", md_en, 1);
    chk("mul_md_func", md_func, 3'b000);
    chk("mul_rwe", reg_write_en, 1);
    chk("mul_illegal", illegal, 0);
    chk("mul_nm_illegal", n_illegal, 1);
    chk("mul_nm_rwe", n_reg_write_en, 0);
    chk("mul_nm_md_en", n_md_en, 0);
    chk("mul_nm_valid", n_out_valid, 1);
    in_inst = 32'h3002D0F3; in_pc = 32'h210;
    tick();
    chk("beq_br", br_type, 3'd1);
    chk("beq_rwe", reg_write_en, 0);
    chk("beq_imm", imm_type, 3'd3);
    in_inst = 32'hFFFFFFFF; in_pc = 32'h214;
    tick();
    chk("csrrwi_alu", alu_func, 4'd11);
    chk("csrrwi_we", csr_write_en, 1);
    chk("csrrwi_zimm", csr_zimm_or_reg, 1);
    chk("csrrwi_rwe", reg_write_en, 1);
    in_valid = 1'b0;
    tick();
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_rwe", reg_write_en, 0);
    chk("ill_mask", cache_write_en, 0);
    chk("ill_pc", out_pc, 32'h214);
    tick();
    chk("ill_drain", out_valid, 0);

    // full and backpressure
    out_ready = 1'b0; in_inst = 32'h00000013;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_pc = 32'h400 + 32'(4 * i);
      tick();
      if (i == 3) chk("full_ready_at4", in_ready, 1);
    end
    chk("full_ready_low", in_ready, 0);
    chk("full_slot_pc", out_pc, 32'h400);
    in_pc = 32'h414;
    tick(); tick();
    chk("bp_ready_low", in_ready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_slot_stable", out_pc, 32'h400);
    out_ready = 1'b1;
    tick();
    chk("bp_out1", out_pc, 32'h404);
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_out2", out_pc, 32'h408);
    in_valid = 1'b0;
    tick();
    chk("bp_out3", out_pc, 32'h40C);
    tick();
    chk("bp_out4", out_pc, 32'h410);
    tick();
    chk("bp_out5", out_pc, 32'h414);
    chk("bp_out5_valid", out_valid, 1);
    tick();
    chk("bp_empty", out_valid, 0);

    // wrap-around with random consumer
    sent = 0; recv = 0;
    for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
      in_valid  = (sent < 20);
      in_pc     = 32'h800 + 32'(4 * sent);
      out_ready = 1'($urandom_range(0, 1));
      #0;
      if (out_valid && out_ready) begin
        chk("wrap_pc", out_pc, 32'h800 + 32'(4 * recv));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("wrap_count", recv, 20);
    tick();
    chk("wrap_no_dup", out_valid, 0);

    // flush with three queued and slot full
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'hA00 + 32'(4 * i);
      tick();
    end
    chk("fl_pre_valid", out_valid, 1);
    chk("fl_pre_pc", out_pc, 32'hA00);
    flush = 1'b1; in_pc = 32'hC00;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_pc_zero", out_pc, 0);
    out_ready = 1'b1;
    tick(); tick();
    chk("fl_dropped", out_valid, 0);
    in_valid = 1'b1; in_pc = 32'hD00;
    tick();
    in_valid = 1'b0;
    tick();
    chk("fl_after_valid", out_valid, 1);
    chk("fl_after_pc", out_pc, 32'hD00);
    tick();

    // asynchronous reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h003100B3; in_pc = 32'hE00;
    tick();
    in_pc = 32'hE04;
    tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_pc", out_pc, 0);
    chk("ar_inst", out_inst, 0);
    chk("ar_rwe", reg_write_en, 0);
    chk("ar_alu", alu_func, 0);
    chk("ar_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_post_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
